systolic_skew_feeder: RTL
=========================

Name: systolic_skew_feeder

Overview:
Transmit-side edge feeder for the 2D systolic multiply array. It accepts one matrix operand as K column beats over a valid/ready handshake and buffers it. It then drives the diagonally skewed 4-bit operand streams that the PE grid's left-edge inputs expect, with lane r delayed r cycles and zero padding outside the data window. One instance feeds the left edge; a second identical instance feeds the top edge.

Parameters:
N, 4, number of array lanes (rows for the left edge, columns for the top edge); legal 1..8.
K, 4, inner dimension, i.e. beats per operand; legal 1..8.
DW, 4, operand element width in bits.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_ni  input  1  asynchronous, active-low reset.
in_valid_i  input  1  an input beat is offered.
in_ready_o  output  1  the feeder can accept a beat.
in_data_i  input  N*DW  beat k; lane r is bits [r*DW +: DW] and holds element A[r][k].
feed_o  output  N*DW  skewed edge stream, one DW slice per lane into that lane's edge PE.
feed_valid_o  output  1  feed_o carries an active stream cycle.
busy_o  output  1  high in LOAD and STREAM.
done_o  output  1  one-cycle pulse after the last stream vector.

Behaviour:
- Reset value (rst_ni low, asynchronous): state IDLE; buffer, beat counter and step counter cleared; feed_o=0, feed_valid_o=0, done_o=0, busy_o=0.
- Reset mid-operation: the partial buffer is discarded, the stream aborts immediately and no done_o pulse is produced.
- in_ready_o is 1 in IDLE and LOAD and 0 in STREAM. A beat is accepted when in_valid_i and in_ready_o are both high at a clock edge.
- IDLE: the first accepted beat is stored at buffer[0] and the state moves to LOAD. If K=1, the state moves straight to STREAM.
- LOAD: each accepted beat is stored at buffer[beat_cnt] and beat_cnt increments. On acceptance of beat K-1 the state moves to STREAM and the step counter t is cleared to 0.
- STREAM: lasts exactly K+N-1 cycles, t = 0..K+N-2.
  - All outputs are registered. The first vector (t=0) appears at the edge after beat K-1 is accepted, so latency from the last beat to the first vector is 1 cycle.
  - For each t, lane r of feed_o = buffer[t-r][r] when 0 <= t-r <= K-1, otherwise 0.
  - feed_valid_o=1 for all K+N-1 cycles.
- Exit from STREAM: at the edge after t=K+N-2, feed_o is 0, feed_valid_o is 0 and done_o is 1 for exactly one cycle. The state is IDLE in that same cycle, so in_ready_o is already 1 and a new beat may be accepted concurrently with the done_o cycle.
- in_valid_i is ignored in STREAM and no beat is lost: the source holds the beat until in_ready_o returns high.
- Widths: the counters are $clog2(K+N) bits wide. No arithmetic is performed on the data path; elements pass through unmodified.
- Back-to-back operands: the minimum period is K load cycles plus K+N-1 stream cycles.

Optional Feature:
Macro SKEW_FEEDER_STALL_EN.
- Defined: adds input stall_i (1 bit).
  - While stall_i=1 in STREAM, t, feed_o and feed_valid_o hold their values and no step advances.
  - The downstream array is expected to clock-gate its PE registers during the stall.
  - stall_i has no effect in IDLE or LOAD.
  - Reset still overrides the stall.
- Undefined: no stall_i port. STREAM is free-running for exactly K+N-1 cycles.

Test Plan:
1. N=4, K=4, beats k0..k3 with lane r of beat k = 4r+k+1, in_valid_i held high -> four accepts on consecutive edges, then 7 stream cycles.
   - t=0 feed_o lanes = {1,0,0,0}; t=3 lanes = {4,7,10,13}; t=6 lanes = {0,0,0,16}.
   - done_o pulses at the following edge.
2. Random in_valid_i gaps during LOAD (e.g. valid 1,0,0,1,1,0,1) -> exactly 4 beats stored in order; stream identical to scenario 1; in_ready_o=0 throughout all 7 stream cycles.
3. in_valid_i=1 held through STREAM with new data -> no acceptance until the done_o cycle; the new beat is accepted in that same cycle and busy_o stays 1 from the next edge.
4. rst_ni pulsed low at stream t=2 -> feed_o=0 and feed_valid_o=0 immediately (asynchronous); no done_o; the next operand streams correctly from t=0.
5. N=1, K=1 corner case -> a single stream cycle with feed_o equal to the beat, then done_o; N=8, K=8 -> 15 stream cycles and lane 7 is nonzero only at t=7..14.
6. SKEW_FEEDER_STALL_EN defined, stall_i=1 for 3 cycles at t=2 -> feed_o is held at the t=2 vector for 4 cycles; the total stream length becomes 10 cycles; done_o is still a single pulse.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - buffers K operand beats and emits diagonally skewed lane streams for a systolic array edge.
// Optional stall input is enabled with SKEW_FEEDER_STALL_EN.
module systolic_skew_feeder #(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
`ifdef SKEW_FEEDER_STALL_EN
    input  logic            stall_i,
`endif
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [N*DW-1:0] in_data_i,
    output logic [N*DW-1:0] feed_o,
    output logic            feed_valid_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int CW = $clog2(K + N);
    localparam logic [CW-1:0] T_LAST    = CW'(K + N - 2);
    localparam logic [CW-1:0] BEAT_LAST = CW'(K - 1);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   beat_cnt_q, t_q, step_sel;
    logic [N*DW-1:0] buf_q [K];
    logic [N*DW-1:0] vec_next;
    logic            accept, last_beat, stall, advance, stream_end;

`ifdef SKEW_FEEDER_STALL_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    assign accept     = in_valid_i && in_ready_o;
    assign last_beat  = accept && (beat_cnt_q == BEAT_LAST);
    assign advance    = (state_q == STREAM) && !stall;
    assign stream_end = advance && (t_q == T_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, LOAD: begin
                if (last_beat) begin
                    state_d = STREAM;
                end else if (accept) begin
                    state_d = LOAD;
                end
            end
            STREAM: begin
                if (stream_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o = (state_q != STREAM);
        busy_o     = (state_q != IDLE);
    end

    // Vector for the step about to be shown; the final beat is forwarded so t=0 needs no extra cycle.
    always_comb begin
        step_sel = (state_q == STREAM) ? t_q + CW'(1) : '0;
        vec_next = '0;
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < K; k++) begin
                if (int'(step_sel) == r + k) begin
                    vec_next[r*DW +: DW] = (last_beat && k == K - 1) ? in_data_i[r*DW +: DW]
                                                                     : buf_q[k][r*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt_q   <= '0;
            t_q          <= '0;
            feed_o       <= '0;
            feed_valid_o <= 1'b0;
            done_o       <= 1'b0;
            for (int k = 0; k < K; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            done_o <= 1'b0;
            if (accept) begin
                for (int k = 0; k < K; k++) begin
                    if (beat_cnt_q == CW'(k)) begin
                        buf_q[k] <= in_data_i;
                    end
                end
                beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CW'(1);
            end
            if (last_beat) begin
                t_q          <= '0;
                feed_o       <= vec_next;
                feed_valid_o <= 1'b1;
            end else if (stream_end) begin
                t_q          <= '0;
                feed_o       <= '0;
                feed_valid_o <= 1'b0;
                done_o       <= 1'b1;
            end else if (advance) begin
                t_q    <= t_q + CW'(1);
                feed_o <= vec_next;
            end
        end
    end

endmodule
